// File: rtl/moore_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : moore_seq_gen
// Description : Moore-style serial pattern transmitter. Sends a PAT_W-bit
//               pattern MSB first, one bit per clock, repeated repeat_cnt
//               times (0 counts as 1). Every output is a registered state
//               output, so there is no combinational path from any input to
//               any output.
//
//               Optional build macro SEQ_GEN_GAP_EN: when defined, GAP_LEN
//               idle zero-bits (valid=0, busy=1) are inserted between
//               repetitions, never after the last one. The GAP_LEN parameter
//               exists only in that build.
//
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous reset, active low
//               start      - burst request, honoured only in IDLE
//               pattern_in - pattern to send (latched on start)
//               repeat_cnt - repetition count (latched on start)
//               data       - serial bit stream
//               valid      - data carries a pattern bit
//               busy       - burst in progress (SHIFT/GAP/DONE)
//               done       - one-cycle pulse after the last bit
//
// Revision    : 1.0 - initial release
// ============================================================================
module moore_seq_gen #(
    parameter int PAT_W   = 5,
    parameter int CNT_W   = 4
`ifdef SEQ_GEN_GAP_EN
    ,
    parameter int GAP_LEN = 2
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             data,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int c_IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]   c_REP_ONE = CNT_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd3;
`ifdef SEQ_GEN_GAP_EN
    localparam logic [1:0] c_GAP   = 2'd2;
    localparam int         c_GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_LEN - 1);
`endif

    logic [1:0]         r_state;
    logic [PAT_W-1:0]   r_pat;
    logic [c_IDX_W-1:0] r_idx;
    logic [CNT_W-1:0]   r_rep;

    logic [1:0]         w_state_nxt;
    logic [PAT_W-1:0]   w_pat_nxt;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0]   w_rep_nxt;

`ifdef SEQ_GEN_GAP_EN
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_GAP_W-1:0] w_gap_nxt;
`endif

    // Next-state and next-datapath logic. The outputs are registered from
    // these next values, so the bit selected here appears on data in the
    // very cycle the FSM sits in SHIFT with that index.
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_idx_nxt   = r_idx;
        w_rep_nxt   = r_rep;
`ifdef SEQ_GEN_GAP_EN
        w_gap_nxt   = r_gap_cnt;
`endif
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_pat_nxt   = pattern_in;
                    w_rep_nxt   = (repeat_cnt == '0) ? c_REP_ONE : repeat_cnt;
                    w_idx_nxt   = c_IDX_MAX;
                    w_state_nxt = c_SHIFT;
                end
            end
            c_SHIFT: begin
                if (r_idx != '0) begin
                    w_idx_nxt = r_idx - 1'b1;
                end else if (r_rep > c_REP_ONE) begin
                    // More repetitions remain: rewind to the MSB.
                    w_rep_nxt = r_rep - 1'b1;
                    w_idx_nxt = c_IDX_MAX;
`ifdef SEQ_GEN_GAP_EN
                    if (GAP_LEN > 0) begin
                        w_gap_nxt   = '0;
                        w_state_nxt = c_GAP;
                    end
`endif
                end else begin
                    w_state_nxt = c_DONE;
                end
            end
`ifdef SEQ_GEN_GAP_EN
            c_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = c_SHIFT;
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end
`endif
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_pat   <= '0;
            r_idx   <= c_IDX_MAX;
            r_rep   <= '0;
            data    <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_idx   <= w_idx_nxt;
            r_rep   <= w_rep_nxt;
            data    <= (w_state_nxt == c_SHIFT) ? w_pat_nxt[w_idx_nxt] : 1'b0;
            valid   <= (w_state_nxt == c_SHIFT);
            busy    <= (w_state_nxt != c_IDLE);
            done    <= (w_state_nxt == c_DONE);
        end
    end

`ifdef SEQ_GEN_GAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= w_gap_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_moore_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_moore_seq_gen
// Description : Self-checking bench for moore_seq_gen. A table of directed
//               bursts is replayed cycle by cycle against hand-computed
//               streams, followed by hand-written sequences for held start,
//               maximum repeat count and asynchronous mid-burst reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_seq_gen;

    localparam int PW = 5;
    localparam int CW = 4;
`ifdef SEQ_GEN_GAP_EN
    localparam int GL = 2;
`else
    localparam int GL = 0;
`endif

    typedef struct {
        logic [PW-1:0] pat;
        logic [CW-1:0] rc;
        int            reps;
        logic [31:0]   stream;
        bit            disturb;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] pattern_in = '0;
    logic [CW-1:0] repeat_cnt = '0;
    logic          data;
    logic          valid;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    moore_seq_gen #(
        .PAT_W(PW),
        .CNT_W(CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern_in (pattern_in),
        .repeat_cnt (repeat_cnt),
        .data       (data),
        .valid      (valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic d, input logic v,
                             input logic b, input logic dn);
        check({name, ".data"},  32'(data),  32'(d));
        check({name, ".valid"}, 32'(valid), 32'(v));
        check({name, ".busy"},  32'(busy),  32'(b));
        check({name, ".done"},  32'(done),  32'(dn));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start pulse, then every cycle of the burst is compared against the
    // hand-written stream (MSB of the stream is the first bit on the wire).
    task automatic run_burst(input logic [PW-1:0] pat, input logic [CW-1:0] rc,
                             input int reps, input logic [31:0] stream,
                             input bit disturb);
        int len;
        int cyc;
        len = reps * PW;
        cyc = 0;
        pattern_in = pat;
        repeat_cnt = rc;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < reps; r++) begin
            for (int b = 0; b < PW; b++) begin
                if (cyc > 0) tick();
                cyc++;
                check_out("shift", stream[len-1-(r*PW+b)], 1'b1, 1'b1, 1'b0);
                if (disturb && cyc == 2) begin
                    start = 1'b1;
                    pattern_in = 5'b01001;
                    repeat_cnt = 4'd7;
                end
                if (disturb && cyc == 4) start = 1'b0;
            end
            if (r < reps - 1) begin
                for (int g = 0; g < GL; g++) begin
                    tick();
                    check_out("gap", 1'b0, 1'b0, 1'b1, 1'b0);
                end
            end
        end
        tick();
        check_out("done", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t        tbl [7];
        logic [12:0] hv;
        logic [12:0] hd;
        logic [12:0] hdat;
        int          nvalid;
        int          nones;
        int          nbusy;
        bit          seen_done;

        tbl[0] = '{5'b10110, 4'd1, 1, 32'b10110, 1'b0};
        tbl[1] = '{5'b10110, 4'd3, 3, 32'b101101011010110, 1'b0};
        tbl[2] = '{5'b10110, 4'd0, 1, 32'b10110, 1'b0};
        tbl[3] = '{5'b10110, 4'd3, 3, 32'b101101011010110, 1'b1};
        tbl[4] = '{5'b01001, 4'd2, 2, 32'b0100101001, 1'b0};
        tbl[5] = '{5'b11111, 4'd1, 1, 32'b11111, 1'b0};
        tbl[6] = '{5'b00001, 4'd2, 2, 32'b0000100001, 1'b0};

        // Reset held with start high: nothing may leave the idle state.
        reset = 1'b0;
        start = 1'b1;
        pattern_in = 5'b10110;
        repeat_cnt = 4'd1;
        #1;
        check_out("rst0", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            tick();
            check_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        start = 1'b0;
        reset = 1'b1;
        tick();
        check_out("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            run_burst(tbl[i].pat, tbl[i].rc, tbl[i].reps, tbl[i].stream, tbl[i].disturb);
        end

        // Start held high: DONE and one IDLE cycle separate the two bursts.
        hv   = 13'b1111100111110;
        hd   = 13'b0000010000001;
        hdat = 13'b1011000101100;
        pattern_in = 5'b10110;
        repeat_cnt = 4'd1;
        start = 1'b1;
        tick();
        for (int i = 0; i < 13; i++) begin
            check("held.valid", 32'(valid), 32'(hv[12-i]));
            check("held.done",  32'(done),  32'(hd[12-i]));
            check("held.data",  32'(data),  32'(hdat[12-i]));
            if (i == 8) start = 1'b0;
            if (i < 12) tick();
        end
        tick();
        check_out("held_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Maximum repeat count must not wrap: 15 reps of all ones.
        pattern_in = 5'b11111;
        repeat_cnt = 4'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        nvalid = 0;
        nones = 0;
        nbusy = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 200 && !seen_done; i++) begin
            if (valid) nvalid++;
            if (data) nones++;
            if (busy && !done) nbusy++;
            if (done) seen_done = 1'b1;
            else tick();
        end
        check("max.done_seen", 32'(seen_done), 32'd1);
        check("max.valid_cycles", 32'(nvalid), 32'd75);
        check("max.ones", 32'(nones), 32'd75);
        check("max.busy_cycles", 32'(nbusy), 32'(75 + GL * 14));
        tick();
        check_out("max_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges while bit 3 is on the wire.
        pattern_in = 5'b10110;
        repeat_cnt = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_out("bit3", 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        check_out("rst_release", 1'b0, 1'b0, 1'b0, 1'b0);
        run_burst(5'b10110, 4'd1, 1, 32'b10110, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/moore_seq_gen.md
Name: moore_seq_gen

Overview:
- Moore-style serial pattern transmitter. Emits a programmable PAT_W-bit pattern, MSB first, one bit per clock on `data`, repeated a requested number of times.
- Default pattern is 10110. It acts as the stimulus source for the 10110 overlapping sequence detector: its `data` output connects directly to the detector's `data` input.
- All outputs are registered state outputs; no input-to-output combinational path.

Parameters:
- PAT_W, 5, pattern length in bits.
- CNT_W, 4, width of the repeat-count input.
- GAP_LEN, 2, idle zero-bits inserted between repetitions. Used only when SEQ_GEN_GAP_EN is defined.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request to begin a burst; sampled only in IDLE.
- pattern_in  input  PAT_W  pattern to send, MSB transmitted first; latched at start.
- repeat_cnt  input  CNT_W  number of pattern repetitions; latched at start; 0 is treated as 1.
- data  output  1  serial bit stream.
- valid  output  1  high when `data` carries a pattern bit.
- busy  output  1  high from the cycle after start acceptance through the DONE state.
- done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - data=0, valid=0, busy=0, done=0.
  - pat_reg=0, bit_idx=PAT_W-1, rep_left=0.
  - Takes effect immediately, including mid-burst. No partial burst resumes after release.
- States: IDLE, SHIFT, GAP (only with macro), DONE. Encoding is free; use binary.
- IDLE:
  - On a rising edge with start=1: pat_reg<=pattern_in; rep_left<=(repeat_cnt==0 ? 1 : repeat_cnt); bit_idx<=PAT_W-1; go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT:
  - data=pat_reg[bit_idx], valid=1, busy=1.
  - Each clock: if bit_idx>0, decrement bit_idx.
  - At bit_idx==0 with rep_left>1: decrement rep_left, reload bit_idx=PAT_W-1, stay in SHIFT (or go to GAP when the macro is defined).
  - At bit_idx==0 with rep_left==1: go to DONE.
- DONE:
  - done=1, busy=1, valid=0, data=0 for exactly one cycle, then IDLE.
- Latency:
  - start sampled at edge k → first bit valid during the cycle after edge k.
  - Burst occupies PAT_W*reps consecutive cycles, with no gaps in default build.
  - done is asserted in the cycle immediately after the last bit.
- Outside SHIFT: data=0 and valid=0.
- start while busy (SHIFT/GAP/DONE) is ignored. pattern_in and repeat_cnt changes during a burst have no effect.
- start held continuously high: a new burst is accepted in the IDLE cycle following DONE. Bursts are therefore separated by exactly 2 non-valid cycles (DONE, IDLE).
- Counter arithmetic:
  - rep_left is CNT_W bits; the maximum of 2^CNT_W-1 repetitions must not wrap.
  - bit_idx is $clog2(PAT_W) bits and never underflows (reloaded at 0).

Optional Feature:
- Macro: SEQ_GEN_GAP_EN.
- Defined:
  - Between repetitions (never after the last), FSM enters GAP for GAP_LEN cycles with data=0, valid=0, busy=1, then returns to SHIFT with bit_idx=PAT_W-1.
  - Burst length becomes PAT_W*reps + GAP_LEN*(reps-1).
  - A gap counter of $clog2(GAP_LEN+1) bits is reset to 0 on reset.
- Undefined:
  - GAP state and gap counter are absent; repetitions are back-to-back.
  - GAP_LEN is unused.

Test Plan:
- Hold reset=0 for 10 ns with start=1 → data=0, valid=0, busy=0, done=0 throughout; no burst starts.
- pattern_in=10110, repeat_cnt=1, 1-cycle start pulse → valid=1 for 5 cycles with data=1,0,1,1,0; done=1 on the 6th cycle; busy low the cycle after.
- pattern_in=10110, repeat_cnt=3, loopback into the detector → data=101101011010110 over 15 cycles, one done pulse. Detector detected pulses 3 times, once after each trailing 0.
  - With SEQ_GEN_GAP_EN and GAP_LEN=2: 2 zero, non-valid cycles appear after bits 5 and 10; total 19 busy-data cycles.
- repeat_cnt=0, start pulse → identical to the repeat_cnt=1 case (5 bits, one done).
- During a burst, assert start and change pattern_in to 01001 and repeat_cnt to 7 → stream and length unchanged; new values are used only when start is high again in IDLE.
- Drop reset to 0 mid-burst at bit 3 (asynchronous, between edges) → data, valid, busy clear immediately. After release, a start pulse produces a full fresh 10110 burst.
